// File: rtl/lvl_queue_reg_pkg.sv
// Shared elevator queue definitions.
//  LVL_W  : bits per floor level (4 floors)
//  DEPTH  : queue entries
//  TAIL_W : tail counter width, holds 0..DEPTH inclusive
// The add-level and in-queue lookup blocks import the same values, so the
// queue bus layout stays consistent across the fed-back loop.
package lvl_queue_reg_pkg;
  localparam int LVL_W  = 2;
  localparam int DEPTH  = 4;
  localparam int TAIL_W = 3;

  // Next-value source for one queue entry.
  typedef enum logic [1:0] {
    ENT_HOLD  = 2'd0,
    ENT_SHIFT = 2'd1,
    ENT_LOAD  = 2'd2
  } ent_sel_e;
endpackage

// File: rtl/lvl_queue_reg.sv
// Registered FIFO of requested floor levels.
// Ports:
//  clk, rst      clock; asynchronous active-high reset
//  add_new_lvl   push pressed_lvl at the tail
//  pressed_lvl   level to push
//  pop_en        head level served; remove it
//  queue         entry i at queue[i*LVL_W +: LVL_W]; entry 0 is the head
//  tail          number of valid entries (0..DEPTH)
//  head_lvl      entry 0
//  head_valid    tail != 0
//  full          tail == DEPTH
//  overflow      sticky: push seen while full (without a pop)
//  underflow     sticky: pop seen while empty (without a push)
// All outputs come straight from flops or from decodes of flops.
module lvl_queue_reg
  import lvl_queue_reg_pkg::*;
#(
  parameter int P_LVL_W  = LVL_W,
  parameter int P_DEPTH  = DEPTH,
  parameter int P_TAIL_W = TAIL_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         add_new_lvl,
  input  logic [P_LVL_W-1:0]           pressed_lvl,
  input  logic                         pop_en,
  output logic [P_DEPTH*P_LVL_W-1:0]   queue,
  output logic [P_TAIL_W-1:0]          tail,
  output logic [P_LVL_W-1:0]           head_lvl,
  output logic                         head_valid,
  output logic                         full,
  output logic                         overflow,
  output logic                         underflow
);

  logic [P_DEPTH-1:0][P_LVL_W-1:0] ent;
  logic [P_TAIL_W-1:0]             tail_q;
  logic                            ovf_q, unf_q;

  logic                empty;
  logic                pop_ok, push_ok;
  logic [P_TAIL_W-1:0] wr_ptr;

  assign empty   = (tail_q == '0);
  assign full    = (tail_q == P_TAIL_W'(P_DEPTH));
  // A pop frees the head, so a push is accepted while full if it pairs with a pop.
  assign pop_ok  = pop_en && !empty;
  assign push_ok = add_new_lvl && (!full || pop_ok);
  // When popping, everything moves down one slot, so the write lands one lower.
  assign wr_ptr  = tail_q - P_TAIL_W'(pop_ok);

  // Per-entry 3-way next-value mux.
  for (genvar i = 0; i < P_DEPTH; i++) begin : g_ent
    ent_sel_e           sel;
    logic [P_LVL_W-1:0] shift_in;

    if (i == P_DEPTH - 1) begin : g_last
      assign shift_in = '0;
    end else begin : g_mid
      assign shift_in = ent[i+1];
    end

    always_comb begin
      sel = ENT_HOLD;
      if (push_ok && (wr_ptr == P_TAIL_W'(i))) sel = ENT_LOAD;
      else if (pop_ok)                         sel = ENT_SHIFT;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) ent[i] <= '0;
      else begin
        case (sel)
          ENT_LOAD:  ent[i] <= pressed_lvl;
          ENT_SHIFT: ent[i] <= shift_in;
          default:   ent[i] <= ent[i];
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tail_q <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      tail_q <= tail_q + P_TAIL_W'(push_ok) - P_TAIL_W'(pop_ok);
      // A simultaneous pop/push never flags: full+pop frees a slot, empty+push fills it.
      if (add_new_lvl && full && !pop_en) ovf_q <= 1'b1;
      if (pop_en && empty && !add_new_lvl) unf_q <= 1'b1;
    end
  end

  assign queue      = ent;
  assign tail       = tail_q;
  assign head_lvl   = ent[0];
  assign head_valid = !empty;
  assign overflow   = ovf_q;
  assign underflow  = unf_q;

endmodule
